spi_master: RTL and testbench
=============================

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter WIDTH, default 8, is the bits per word, with WIDTH >= 2.
REQ-002 Parameter CLK_DIV, default 2, is the sclk half-period in clk cycles, with CLK_DIV >= 1.
REQ-003 Parameter CS_GAP, default 4, is the minimum number of clk cycles cs_n stays high between frames, with CS_GAP >= 1.
REQ-004 clk, input, 1: the single system clock; all logic is on its rising edge.
REQ-005 rst_n, input, 1: reset, synchronous, active-low.
REQ-006 tx_data, input, WIDTH: word to transmit, sent MSB first.
REQ-007 tx_last, input, 1: the accepted word ends the frame (cs_n deasserts after it).
REQ-008 tx_valid, input, 1: tx_data/tx_last are valid.
REQ-009 tx_ready, output, 1: block can accept a word this cycle.
REQ-010 rx_data, output, WIDTH: last word received on miso.
REQ-011 rx_valid, output, 1: one-cycle pulse, rx_data updated.
REQ-012 busy, output, 1: high whenever state is not IDLE.
REQ-013 sclk, output, 1: SPI clock, mode 0 (idles low).
REQ-014 cs_n, output, 1: active-low chip select.
REQ-015 mosi, output, 1: serial data out.
REQ-016 miso, input, 1: serial data in, already synchronous to clk.

Function
REQ-017 A word is accepted on a cycle with tx_valid && tx_ready; tx_data/tx_last are latched and later changes are ignored.
REQ-018 States: IDLE, SETUP, HIGH, LOW, WAIT, GAP.
REQ-019 IDLE: cs_n=1, sclk=0, tx_ready=1; on accept -> SETUP, cs_n=0 and mosi=MSB at the next edge.
REQ-020 SETUP: lasts CLK_DIV cycles with sclk=0, then -> HIGH.
REQ-021 HIGH: lasts CLK_DIV cycles with sclk=1; at its final edge miso is shifted into the rx register, sclk goes 0 and mosi advances to the next bit.
REQ-022 After the WIDTH-th HIGH phase the word is done; otherwise -> LOW for CLK_DIV cycles, then -> HIGH.
REQ-023 Latency: exactly 2*WIDTH*CLK_DIV clk cycles from cs_n falling to the rx_valid pulse (32 for the defaults).
REQ-024 At word done, rx_data takes the full received word and rx_valid is 1 for exactly one cycle.
REQ-025 Word done with tx_last=1: cs_n goes high at the same edge -> GAP.
REQ-026 Word done with tx_last=0: -> WAIT, with cs_n=0, sclk=0, tx_ready=1.
REQ-027 In WAIT, an accept -> SETUP with cs_n held low; with no accept the block stays in WAIT indefinitely.
REQ-028 GAP: cs_n=1 and tx_ready=0 for CS_GAP cycles, then -> IDLE.
REQ-029 tx_ready is 0 in SETUP, HIGH, LOW and GAP.
REQ-030 mosi holds its bit for a full sclk period and is stable across each rising sclk edge.
REQ-031 The bit counter counts exactly WIDTH HIGH phases per word, with no wrap and no extra sclk pulse.
REQ-032 rx_valid and tx_ready may be high in the same cycle (WAIT entry); an accept in that cycle is legal.
REQ-033 In IDLE, mosi is 0.

Reset
REQ-034 rst_n=0 at any clk edge forces IDLE, sclk=0, cs_n=1, mosi=0, rx_valid=0, rx_data=0, busy=0 and tx_ready=0 during reset.
REQ-035 Reset mid-word aborts the transfer: cs_n goes high at the reset edge, no rx_valid pulse occurs, and the partial word is discarded.
REQ-036 tx_ready returns to 1 on the first cycle after rst_n is released.

Structure
REQ-037 Package spi_pkg holds the state enum spi_state_t and the default WIDTH, CLK_DIV and CS_GAP constants; it is shared with the SPI slave.
REQ-038 Sub-module spi_clk_gen implements the CLK_DIV half-period counter with a phase-end strobe, cleared on each state change.
REQ-039 Shift, bit-count and state logic live in spi_master; all outputs are registered.

Verification
REQ-040 Defaults, miso looped to mosi; send 0x3C (last=0) then 0x80 (last=1) -> rx_data 0x3C then 0x80, cs_n low across both words, 16 sclk pulses.
REQ-041 Connected to spi_slave with din=0xA5; send 0x36 then 0x1B in one frame -> rx_data 0xA5 first, and the slave's dout matches what was sent.
REQ-042 Latency: CLK_DIV=2 -> rx_valid 32 cycles after cs_n falls; CLK_DIV=1 -> 16 cycles.
REQ-043 Reset mid-word: assert rst_n=0 after 3 bits -> cs_n=1 and sclk=0 the next cycle, no rx_valid, and the next frame is received correctly.
REQ-044 Burst stall: hold tx_valid=0 for 10 cycles after a last=0 word -> cs_n stays low, sclk stays 0, and the transfer resumes correctly.
REQ-045 Frame gap: two back-to-back last=1 words -> cs_n high for >= CS_GAP cycles between them, and tx_ready is low throughout GAP.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding and default frame/timing constants.
// Used by both the SPI master and the SPI slave.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    WAIT,
    GAP
  } spi_state_t;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_CLK_DIV = 2;
  localparam int DEF_CS_GAP  = 4;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period timer for the SPI clock: strobes phase_end on the last clk cycle of
// each CLK_DIV-long phase. Restarts whenever the master changes state.
module spi_clk_gen import spi_pkg::*; #(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic phase_end
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt <= '0;
    end else if (phase_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign phase_end = (cnt == LAST);

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: shifts WIDTH-bit words MSB first, keeps cs_n low across a
// multi-word frame and enforces a minimum cs_n-high gap between frames.
module spi_master import spi_pkg::*; #(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int CS_GAP  = DEF_CS_GAP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_last,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             sclk,
  output logic             cs_n,
  output logic             mosi,
  input  logic             miso
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

  spi_state_t state, state_next;

  logic             phase_end;
  logic             state_change;
  logic             accept;
  logic             high_end;
  logic             word_done;
  logic             bit_last;
  logic             gap_done;
  logic             last_q;
  logic [BW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;
  // Only the bits not yet on mosi are kept; the MSB goes straight to mosi on accept.
  logic [WIDTH-2:0] tx_shift;
  logic [WIDTH-1:0] tx_shift_wide;
  logic [WIDTH-2:0] rx_shift;
  logic [WIDTH-1:0] rx_shift_wide;

  assign accept        = tx_valid && tx_ready;
  assign bit_last      = (bit_cnt == LAST_BIT);
  assign gap_done      = (gap_cnt == GAP_LAST);
  assign high_end      = (state == HIGH) && phase_end;
  assign word_done     = high_end && bit_last;
  assign state_change  = (state_next != state);
  assign tx_shift_wide = {tx_shift, 1'b0};
  assign rx_shift_wide = {rx_shift, miso};

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (state_change),
    .phase_end (phase_end)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, WAIT: if (accept) state_next = SETUP;
      SETUP:      if (phase_end) state_next = HIGH;
      HIGH: begin
        if (phase_end) begin
          if (!bit_last)   state_next = LOW;
          else if (last_q) state_next = GAP;
          else             state_next = WAIT;
        end
      end
      LOW:        if (phase_end) state_next = HIGH;
      GAP:        if (gap_done) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change on the same edge as the FSM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk     <= 1'b0;
      cs_n     <= 1'b1;
      mosi     <= 1'b0;
      tx_ready <= 1'b0;
      busy     <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      last_q   <= 1'b0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
    end else begin
      sclk     <= (state_next == HIGH);
      cs_n     <= (state_next == IDLE) || (state_next == GAP);
      tx_ready <= (state_next == IDLE) || (state_next == WAIT);
      busy     <= (state_next != IDLE);
      rx_valid <= word_done;

      if (accept) begin
        tx_shift <= tx_data[WIDTH-2:0];
        mosi     <= tx_data[WIDTH-1];
        last_q   <= tx_last;
        bit_cnt  <= '0;
      end else if (high_end) begin
        tx_shift <= tx_shift_wide[WIDTH-2:0];
        mosi     <= tx_shift_wide[WIDTH-1];
        rx_shift <= rx_shift_wide[WIDTH-2:0];
        if (!bit_last) bit_cnt <= bit_cnt + BW'(1);
      end

      if (word_done) rx_data <= rx_shift_wide;

      if ((state_next == IDLE) || (state_next == GAP)) mosi <= 1'b0;

      if ((state == GAP) && !gap_done) begin
        gap_cnt <= gap_cnt + GW'(1);
      end else if (state != GAP) begin
        gap_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: table of loopback words plus hand-written sequences
// for latency, reset abort, burst stall, frame gap and a behavioural slave.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_last = 1'b0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, rx_valid, busy, sclk, cs_n, mosi, miso;
  logic [7:0] rx_data;

  logic [7:0] f_tx_data = '0;
  logic       f_tx_last = 1'b0;
  logic       f_tx_valid = 1'b0;
  logic       f_tx_ready, f_rx_valid, f_busy, f_sclk, f_cs_n, f_mosi;
  logic [7:0] f_rx_data;

  logic       use_slave = 1'b0;
  logic [7:0] s_din = 8'hA5;
  logic [7:0] s_tx = 8'hA5;
  logic [7:0] s_rx = '0;
  logic [7:0] s_dout [4];
  int         s_words = 0;
  int         s_rx_bits = 0;
  int         s_fall_bits = 0;
  logic       sclk_d = 1'b0;

  int total = 0, bad = 0;
  int cyc = 0, t_accept = 0;
  int sclk_pulses = 0, sclk_falls = 0, cs_rises = 0, rx_pulses = 0;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic [7:0] exp_rx;
    logic       exp_ready;
  } vec_t;
  vec_t vecs [6];

  assign miso = use_slave ? s_tx[7] : mosi;

  spi_master dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_last(tx_last), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso)
  );

  spi_master #(.WIDTH(8), .CLK_DIV(1), .CS_GAP(4)) dut_fast (
    .clk(clk), .rst_n(rst_n), .tx_data(f_tx_data), .tx_last(f_tx_last), .tx_valid(f_tx_valid),
    .tx_ready(f_tx_ready), .rx_data(f_rx_data), .rx_valid(f_rx_valid), .busy(f_busy),
    .sclk(f_sclk), .cs_n(f_cs_n), .mosi(f_mosi), .miso(f_mosi)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge sclk) sclk_pulses++;
  always @(negedge sclk) sclk_falls++;
  always @(posedge cs_n) cs_rises++;
  always @(posedge clk) if (rx_valid === 1'b1) rx_pulses++;

  // Mode-0 slave sampled at negedge clk: captures mosi on sclk rise, shifts miso on sclk fall.
  always @(negedge clk) begin
    if (cs_n !== 1'b0) begin
      s_tx        <= s_din;
      s_rx_bits   <= 0;
      s_fall_bits <= 0;
    end else begin
      if (sclk && !sclk_d) begin
        s_rx <= {s_rx[6:0], mosi};
        if (s_rx_bits == 7) begin
          s_dout[s_words % 4] <= {s_rx[6:0], mosi};
          s_words   <= s_words + 1;
          s_rx_bits <= 0;
        end else begin
          s_rx_bits <= s_rx_bits + 1;
        end
      end
      if (!sclk && sclk_d) begin
        if (s_fall_bits == 7) begin
          s_tx        <= s_din;
          s_fall_bits <= 0;
        end else begin
          s_tx        <= {s_tx[6:0], 1'b0};
          s_fall_bits <= s_fall_bits + 1;
        end
      end
    end
    sclk_d <= sclk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns just after the accepting posedge.
  task automatic applyStimulus(input logic [7:0] d, input logic l);
    int k = 0;
    while (tx_ready !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      checkOutput("tx_ready_wait", tx_ready, 1);
    end else begin
      tx_data  = d;
      tx_last  = l;
      tx_valid = 1'b1;
      @(posedge clk);
      #1;
      t_accept = cyc;
      tx_valid = 1'b0;
      tx_data  = ~d;
      tx_last  = ~l;
    end
  endtask

  // Returns at the negedge where rx_valid is seen.
  task automatic waitRx(output logic [7:0] d, output int lat);
    int k = 0;
    d = 'x;
    lat = -1;
    while (k < 400) begin
      @(negedge clk);
      if (rx_valid === 1'b1) begin
        d = rx_data;
        lat = cyc - t_accept;
        break;
      end
      k++;
    end
    if (k >= 400) checkOutput("rx_valid_wait", rx_valid, 1);
  endtask

  task automatic waitIdle();
    int k = 0;
    while (busy !== 1'b0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) checkOutput("idle_wait", busy, 0);
  endtask

  initial begin
    logic [7:0] d;
    int lat, k, sp0, cr0, rp0, sf0, sw0, stall_bad, gap_cs_bad;

    vecs[0] = '{8'h3C, 1'b0, 8'h3C, 1'b1};
    vecs[1] = '{8'h80, 1'b1, 8'h80, 1'b0};
    vecs[2] = '{8'hFF, 1'b0, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 1'b0, 8'h00, 1'b1};
    vecs[4] = '{8'h01, 1'b1, 8'h01, 1'b0};
    vecs[5] = '{8'hA5, 1'b1, 8'hA5, 1'b0};

    repeat (3) @(negedge clk);
    checkOutput("reset_cs_n", cs_n, 1);
    checkOutput("reset_sclk", sclk, 0);
    checkOutput("reset_mosi", mosi, 0);
    checkOutput("reset_rx_valid", rx_valid, 0);
    checkOutput("reset_rx_data", rx_data, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_tx_ready", tx_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("release_tx_ready", tx_ready, 1);

    // Fast instance: CLK_DIV=1 halves the word latency.
    f_tx_data = 8'h96;
    f_tx_last = 1'b1;
    f_tx_valid = 1'b1;
    @(posedge clk);
    #1;
    t_accept = cyc;
    f_tx_valid = 1'b0;
    f_tx_data = 8'h00;
    k = 0;
    while (f_rx_valid !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    checkOutput("fast_rx_valid", f_rx_valid, 1);
    checkOutput("fast_latency", cyc - t_accept, 16);
    checkOutput("fast_rx_data", f_rx_data, 8'h96);

    @(negedge clk);
    sp0 = sclk_pulses;
    cr0 = cs_rises;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].data, vecs[i].last);
      if (i == 0) checkOutput("cs_n_fall_at_accept", cs_n, 0);
      waitRx(d, lat);
      checkOutput($sformatf("vec%0d_rx_data", i), d, vecs[i].exp_rx);
      checkOutput($sformatf("vec%0d_tx_ready_at_rx", i), tx_ready, vecs[i].exp_ready);
      if (i == 0) begin
        checkOutput("latency_div2", lat, 32);
        checkOutput("cs_n_low_in_wait", cs_n, 0);
      end
      if (i == 1) begin
        checkOutput("frame_sclk_pulses", sclk_pulses - sp0, 16);
        checkOutput("frame_cs_rises", cs_rises - cr0, 1);
      end
    end

    waitIdle();
    checkOutput("idle_mosi", mosi, 0);
    checkOutput("idle_cs_n", cs_n, 1);
    checkOutput("idle_sclk", sclk, 0);

    // Burst stall: WAIT holds cs_n low with sclk parked until the next word arrives.
    applyStimulus(8'h12, 1'b0);
    waitRx(d, lat);
    checkOutput("stall_first_rx", d, 8'h12);
    @(negedge clk);
    checkOutput("rx_valid_one_cycle", rx_valid, 0);
    stall_bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (cs_n !== 1'b0 || sclk !== 1'b0 || busy !== 1'b1 || tx_ready !== 1'b1) stall_bad++;
      @(negedge clk);
    end
    checkOutput("stall_hold", stall_bad, 0);
    applyStimulus(8'h34, 1'b1);
    waitRx(d, lat);
    checkOutput("stall_resume_rx", d, 8'h34);

    // Frame gap between two single-word frames.
    applyStimulus(8'h11, 1'b1);
    waitRx(d, lat);
    checkOutput("gap_first_rx", d, 8'h11);
    k = 0;
    gap_cs_bad = 0;
    while (tx_ready !== 1'b1 && k < 50) begin
      if (cs_n !== 1'b1) gap_cs_bad++;
      k++;
      @(negedge clk);
    end
    checkOutput("gap_ready_low_cycles", k, 4);
    checkOutput("gap_cs_n_high", gap_cs_bad, 0);
    applyStimulus(8'h22, 1'b1);
    checkOutput("gap_second_cs_n", cs_n, 0);
    waitRx(d, lat);
    checkOutput("gap_second_rx", d, 8'h22);

    // Reset mid-word after three bits.
    waitIdle();
    rp0 = rx_pulses;
    applyStimulus(8'hC3, 1'b1);
    sf0 = sclk_falls;
    k = 0;
    while ((sclk_falls - sf0) < 3 && k < 100) begin
      @(negedge clk);
      k++;
    end
    checkOutput("abort_three_bits", sclk_falls - sf0, 3);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort_cs_n", cs_n, 1);
    checkOutput("abort_sclk", sclk, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_rx_data", rx_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("abort_release_ready", tx_ready, 1);
    repeat (40) @(negedge clk);
    checkOutput("abort_no_rx_valid", rx_pulses - rp0, 0);
    applyStimulus(8'h5A, 1'b1);
    waitRx(d, lat);
    checkOutput("abort_next_rx", d, 8'h5A);

    // Behavioural slave answering 0xA5 to a two-word frame.
    waitIdle();
    use_slave = 1'b1;
    @(negedge clk);
    sw0 = s_words;
    applyStimulus(8'h36, 1'b0);
    waitRx(d, lat);
    checkOutput("slave_rx0", d, 8'hA5);
    applyStimulus(8'h1B, 1'b1);
    waitRx(d, lat);
    checkOutput("slave_rx1", d, 8'hA5);
    @(negedge clk);
    checkOutput("slave_word_count", s_words - sw0, 2);
    checkOutput("slave_dout0", s_dout[sw0 % 4], 8'h36);
    checkOutput("slave_dout1", s_dout[(sw0 + 1) % 4], 8'h1B);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
